fp_add_issue: RTL and testbench
===============================

FP_ADD_ISSUE -- requirements
Module: fp_add_issue

Interface
REQ-001 SHALL have parameter IN_DEPTH, default 4, input operand FIFO depth in entries (power of two, ≥2).
REQ-002 SHALL have parameter RES_DEPTH, default 2, result buffer depth in entries (power of two, ≥2).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1: operand-pair handshake.
REQ-006 SHALL have ports in_a, in_b  input  27 each: operands, format {sign[26], expt[25:18], mant[17:0]}, hidden leading one.
REQ-007 SHALL have ports add_first, add_second  output  27 each: operands to the downstream one-register-stage adder.
REQ-008 SHALL have port add_out  input  27  adder result, valid the cycle after its operands were driven.
REQ-009 SHALL have ports res_valid output 1, res_ready input 1, res_data output 27: result handshake.
REQ-010 SHALL have port in_count  output  $clog2(IN_DEPTH)+1  current input FIFO occupancy.

Function
REQ-011 SHALL accept a pair on a rising edge when in_valid && in_ready; in_ready = (in_count < IN_DEPTH), with no same-cycle bypass when full.
REQ-012 SHALL drive add_first/add_second from the FIFO head every cycle, and drive zero when the FIFO is empty.
REQ-013 SHALL issue, popping the head, when the FIFO is non-empty and res_count + inflight − (res_valid && res_ready) < RES_DEPTH.
REQ-014 SHALL register a 1-bit inflight flag set on issue, and capture add_out into the result buffer on the following edge.
REQ-015 SHALL give a minimum latency of 3 cycles: pair accepted at edge 0, issued in cycle 1, captured at edge 2, res_valid high in cycle 3.
REQ-016 SHALL keep the result buffer in FIFO order; res_data = head; res_valid = (res_count != 0); pop on res_valid && res_ready.
REQ-017 SHALL hold res_data stable while res_valid && !res_ready.
REQ-018 SHALL support a simultaneous push and pop on both FIFOs in one cycle, with occupancy unchanged; pointers wrap modulo depth.
REQ-019 SHALL clear bit 26 of every captured result; operand sign bits are carried to the adder unchanged.
REQ-020 SHALL sustain one result per cycle when res_ready is held high.

Reset
REQ-021 SHALL, while rst is low, force in_count=0, res_valid=0, inflight=0, res_data=0, add_first/add_second=0, and in_ready=1 after release.
REQ-022 SHALL discard, on reset mid-operation, all buffered and in-flight operations; no result emerges after release.

Configuration
REQ-023 SHALL, with macro FP_ADD_ZERO_BYPASS_EN defined, treat an operand with bits [25:0]==0 as zero at issue.
- One zero operand: the result is the other operand with bit 26 cleared.
- Both operands zero: the result is 0.
- The bypass value is registered alongside inflight and selected over add_out at capture.
- Latency and ordering are identical to the non-bypass path.
REQ-024 SHALL, without FP_ADD_ZERO_BYPASS_EN, always capture add_out, with no zero detection logic present.

Verification
REQ-025 SHALL check single op: in_a=27'h1FC0000, in_b=27'h1F80000 at cycle 0, with the adder stub returning 27'h0ABCDEF -> res_valid in cycle 3, res_data=27'h0ABCDEF.
REQ-026 SHALL check backpressure: res_ready=0 while pushing 6 pairs.
- Expected: at most RES_DEPTH results buffered and in_ready low after 4+2 accepted.
- Then release res_ready -> 6 results returned in order, none lost or duplicated.
REQ-027 SHALL check streaming: 16 back-to-back pairs with res_ready=1 -> 16 results on consecutive cycles starting cycle 3.
REQ-028 SHALL check bypass (macro on): in_a=0, in_b=27'h5FC1234 -> res_data=27'h1FC1234, ignoring add_out.
- Both operands zero -> res_data=0.
REQ-029 SHALL check reset: assert rst low for 1 cycle with 3 pairs buffered and 1 in flight -> res_valid=0, in_count=0 immediately, no results after release.
REQ-030 SHALL check simultaneous ops: with the FIFO full, a pop and res_ready in the same cycle -> in_ready rises next cycle, and the count stays consistent.

Source files
------------

// File: rtl/fp_add_issue_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fp_add_issue_if                                               |
// | Purpose  : Bundles the operand, adder-link and result signals of         |
// |            fp_add_issue into one interface.                              |
// | Modports : master - environment side (drives operands, add_out,          |
// |                     res_ready)                                           |
// |            slave  - fp_add_issue side                                    |
// | Signals  : in_valid/in_ready/in_a/in_b   operand-pair handshake          |
// |            add_first/add_second          operands to external adder      |
// |            add_out                       adder result (1-cycle latency)  |
// |            res_valid/res_ready/res_data  result handshake                |
// |            in_count                      input FIFO occupancy            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface fp_add_issue_if #(
  parameter int IN_DEPTH = 4
) ();
  localparam int CW = $clog2(IN_DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [26:0]   in_a;
  logic [26:0]   in_b;
  logic [26:0]   add_first;
  logic [26:0]   add_second;
  logic [26:0]   add_out;
  logic          res_valid;
  logic          res_ready;
  logic [26:0]   res_data;
  logic [CW-1:0] in_count;

  modport master (
    output in_valid, in_a, in_b, add_out, res_ready,
    input  in_ready, add_first, add_second, res_valid, res_data, in_count
  );

  modport slave (
    input  in_valid, in_a, in_b, add_out, res_ready,
    output in_ready, add_first, add_second, res_valid, res_data, in_count
  );
endinterface
`default_nettype wire

// File: rtl/fp_add_issue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fp_add_issue                                                  |
// | Purpose  : Buffers operand pairs, issues them to an external adder with  |
// |            one register stage, and collects results into an ordered      |
// |            result buffer with valid/ready output.                        |
// | Ports    : clk  - clock, rising edge                                     |
// |            rst  - asynchronous, active-low reset                         |
// |            bus  - fp_add_issue_if.slave (operand, adder, result signals) |
// | Params   : IN_DEPTH  - operand FIFO depth (power of two, >= 2)           |
// |            RES_DEPTH - result buffer depth (power of two, >= 2)          |
// | Options  : FP_ADD_ZERO_BYPASS_EN - operands with bits [25:0]==0 are      |
// |            treated as zero and the result is formed locally.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fp_add_issue #(
  parameter int IN_DEPTH  = 4,
  parameter int RES_DEPTH = 2
) (
  input  wire logic    clk,
  input  wire logic    rst,
  fp_add_issue_if.slave bus
);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int ICW = IAW + 1;
  localparam int RAW = $clog2(RES_DEPTH);
  localparam int RCW = RAW + 1;

  localparam logic [ICW-1:0] IN_FULL   = ICW'(IN_DEPTH);
  localparam logic [RCW:0]   RES_LIMIT = (RCW+1)'(RES_DEPTH);
  localparam logic [26:0]    MAG_MASK  = 27'h3FFFFFF;

  // Operand FIFO
  logic [26:0]    in_a_mem [IN_DEPTH];
  logic [26:0]    in_b_mem [IN_DEPTH];
  logic [IAW-1:0] in_wr_q, in_wr_d;
  logic [IAW-1:0] in_rd_q, in_rd_d;
  logic [ICW-1:0] in_cnt_q, in_cnt_d;

  // Result buffer
  logic [26:0]    res_mem [RES_DEPTH];
  logic [RAW-1:0] res_wr_q, res_wr_d;
  logic [RAW-1:0] res_rd_q, res_rd_d;
  logic [RCW-1:0] res_cnt_q, res_cnt_d;

  logic           inflight_q;

  logic           in_push;
  logic           in_empty;
  logic           issue;
  logic           res_pop;
  logic           res_valid;
  logic [26:0]    head_a;
  logic [26:0]    head_b;
  logic [26:0]    res_wdata;
  logic [RCW:0]   res_commit;

  assign in_empty = (in_cnt_q == '0);
  assign head_a   = in_a_mem[in_rd_q];
  assign head_b   = in_b_mem[in_rd_q];

  assign bus.in_ready = (in_cnt_q < IN_FULL);
  assign in_push      = bus.in_valid && bus.in_ready;
  assign bus.in_count = in_cnt_q;

  assign bus.add_first  = in_empty ? '0 : head_a;
  assign bus.add_second = in_empty ? '0 : head_b;

  assign res_valid     = (res_cnt_q != '0);
  assign res_pop       = res_valid && bus.res_ready;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_valid ? res_mem[res_rd_q] : '0;

  // Slots already committed after this cycle's pop: buffered plus the one
  // still in the adder. res_count >= 1 whenever a pop happens, so no underflow.
  assign res_commit = {1'b0, res_cnt_q} + {{RCW{1'b0}}, inflight_q}
                    - {{RCW{1'b0}}, res_pop};
  assign issue      = !in_empty && (res_commit < RES_LIMIT);

`ifdef FP_ADD_ZERO_BYPASS_EN
  logic        a_zero;
  logic        b_zero;
  logic        byp_sel_q, byp_sel_d;
  logic [26:0] byp_val_q, byp_val_d;

  assign a_zero = ((head_a & MAG_MASK) == '0);
  assign b_zero = ((head_b & MAG_MASK) == '0);

  always_comb begin
    byp_sel_d = 1'b0;
    byp_val_d = '0;
    if (issue) begin
      byp_sel_d = a_zero || b_zero;
      if (a_zero && b_zero) byp_val_d = '0;
      else if (a_zero)      byp_val_d = head_b & MAG_MASK;
      else if (b_zero)      byp_val_d = head_a & MAG_MASK;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byp_sel_q <= 1'b0;
      byp_val_q <= '0;
    end else begin
      byp_sel_q <= byp_sel_d;
      byp_val_q <= byp_val_d;
    end
  end

  assign res_wdata = byp_sel_q ? byp_val_q : (bus.add_out & MAG_MASK);
`else
  assign res_wdata = bus.add_out & MAG_MASK;
`endif

  // Next-state for pointers and counters; power-of-two depths wrap naturally.
  always_comb begin
    in_wr_d   = in_wr_q;
    in_rd_d   = in_rd_q;
    in_cnt_d  = in_cnt_q + ICW'(in_push) - ICW'(issue);
    res_wr_d  = res_wr_q;
    res_rd_d  = res_rd_q;
    res_cnt_d = res_cnt_q + RCW'(inflight_q) - RCW'(res_pop);
    if (in_push)    in_wr_d  = in_wr_q + IAW'(1);
    if (issue)      in_rd_d  = in_rd_q + IAW'(1);
    if (inflight_q) res_wr_d = res_wr_q + RAW'(1);
    if (res_pop)    res_rd_d = res_rd_q + RAW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_wr_q    <= '0;
      in_rd_q    <= '0;
      in_cnt_q   <= '0;
      res_wr_q   <= '0;
      res_rd_q   <= '0;
      res_cnt_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      in_wr_q    <= in_wr_d;
      in_rd_q    <= in_rd_d;
      in_cnt_q   <= in_cnt_d;
      res_wr_q   <= res_wr_d;
      res_rd_q   <= res_rd_d;
      res_cnt_q  <= res_cnt_d;
      inflight_q <= issue;
    end
  end

  // Storage arrays carry no reset: their contents are only visible through
  // the occupancy counters, which are reset.
  always_ff @(posedge clk) begin
    if (in_push) begin
      in_a_mem[in_wr_q] <= bus.in_a;
      in_b_mem[in_wr_q] <= bus.in_b;
    end
    if (inflight_q) begin
      res_mem[res_wr_q] <= res_wdata;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fp_add_issue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fp_add_issue                                               |
// | Purpose  : Scoreboard bench for fp_add_issue with a one-stage adder stub.|
// | Options  : FP_ADD_ZERO_BYPASS_EN selects the bypass expectations.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fp_add_issue;
  localparam int IN_DEPTH  = 4;
  localparam int RES_DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  fp_add_issue_if #(.IN_DEPTH(IN_DEPTH)) bus ();

  fp_add_issue #(.IN_DEPTH(IN_DEPTH), .RES_DEPTH(RES_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder stub: one pair returns a fixed value; otherwise a ^ b with bit 26
  // and bit 0 toggled, so sign clearing and zero bypass are both observable.
  function automatic logic [26:0] stub_f(input logic [26:0] a, input logic [26:0] b);
    if (a == 27'h1FC0000 && b == 27'h1F80000) return 27'h0ABCDEF;
    return a ^ b ^ 27'h4000001;
  endfunction

  function automatic logic [26:0] exp_f(input logic [26:0] a, input logic [26:0] b);
`ifdef FP_ADD_ZERO_BYPASS_EN
    if (a[25:0] == 26'd0 && b[25:0] == 26'd0) return 27'h0;
    if (a[25:0] == 26'd0) return {1'b0, b[25:0]};
    if (b[25:0] == 26'd0) return {1'b0, a[25:0]};
`endif
    return stub_f(a, b) & 27'h3FFFFFF;
  endfunction

  always @(posedge clk) bus.add_out <= stub_f(bus.add_first, bus.add_second);

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [26:0] exp_q[$];
  int          pop_cyc_q[$];
  int          pop_cnt  = 0;
  int          acc_cyc  = 0;
  logic        held     = 1'b0;
  logic [26:0] held_val = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: compares every accepted result against the scoreboard head and
  // checks that a stalled result does not change.
  always @(negedge clk) begin
    if (rst && bus.res_valid) begin
      if (held) chk("res_hold", 32'(bus.res_data), 32'(held_val));
      if (bus.res_ready) begin
        held = 1'b0;
        pop_cnt++;
        pop_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL res_unexpected: actual %h required no result", bus.res_data);
        end else begin
          chk("res_data", 32'(bus.res_data), 32'(exp_q.pop_front()));
        end
      end else begin
        held     = 1'b1;
        held_val = bus.res_data;
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [26:0] a, input logic [26:0] b, input logic [26:0] e);
    int w = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    while (!bus.in_ready && w < 200) begin
      sync();
      w++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    end else begin
      exp_q.push_back(e);
      acc_cyc = cyc;
    end
    sync();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      sync();
      w++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Single pair on an idle block: checks issue in cycle 1 and result in cycle 3.
  task automatic single(input string nm, input logic [26:0] a, input logic [26:0] b,
                        input logic [26:0] e);
    bus.res_ready = 1'b1;
    sync();
    send(a, b, e);
    @(negedge clk);
    chk({nm, "_add_first"}, 32'(bus.add_first), 32'(a));
    chk({nm, "_add_second"}, 32'(bus.add_second), 32'(b));
    chk({nm, "_valid_c1"}, 32'(bus.res_valid), 32'd0);
    @(negedge clk);
    chk({nm, "_valid_c2"}, 32'(bus.res_valid), 32'd0);
    @(negedge clk);
    chk({nm, "_valid_c3"}, 32'(bus.res_valid), 32'd1);
    @(negedge clk);
  endtask

  task automatic fill_six();
    bus.res_ready = 1'b0;
    sync();
    for (int i = 0; i < 6; i++) begin
      logic [26:0] a = 27'h0100000 + 27'(i * 27'h11);
      logic [26:0] b = 27'h0020000 + 27'(i * 27'h303);
      send(a, b, exp_f(a, b));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc;
    int first_acc;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.res_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_in_count", 32'(bus.in_count), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data", 32'(bus.res_data), 32'd0);
    chk("rst_add_first", 32'(bus.add_first), 32'd0);
    chk("rst_add_second", 32'(bus.add_second), 32'd0);
    sync();
    sync();
    rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed single operations
    single("op_fixed", 27'h1FC0000, 27'h1F80000, 27'h0ABCDEF);
    single("op_small", 27'h0000003, 27'h0000005, 27'h0000007);
    single("op_sign", 27'h4000010, 27'h0000100, 27'h0000111);
    single("op_ones", 27'h7FFFFFF, 27'h2AAAAAA, 27'h1555554);
`ifdef FP_ADD_ZERO_BYPASS_EN
    single("byp_one", 27'h0000000, 27'h5FC1234, 27'h1FC1234);
    single("byp_both", 27'h0000000, 27'h0000000, 27'h0000000);
`else
    single("nobyp_one", 27'h0000000, 27'h5FC1234, 27'h1FC1235);
    single("nobyp_both", 27'h0000000, 27'h0000000, 27'h0000001);
`endif
    wait_drain();

    // Streaming: 16 back-to-back pairs, one result per cycle
    bus.res_ready = 1'b1;
    sync();
    pop_cyc_q.delete();
    first_acc = 0;
    for (int i = 0; i < 16; i++) begin
      logic [26:0] a = 27'h0400000 | 27'(i * 27'h1021);
      logic [26:0] b = 27'h0081000 ^ 27'(i * 27'h0777);
      send(a, b, exp_f(a, b));
      if (i == 0) first_acc = acc_cyc;
    end
    chk("stream_in_count", 32'(bus.in_count), 32'd1);
    wait_drain();
    chk("stream_n", 32'(pop_cyc_q.size()), 32'd16);
    if (pop_cyc_q.size() == 16) begin
      chk("stream_latency", 32'(pop_cyc_q[0] - first_acc), 32'd3);
      chk("stream_span", 32'(pop_cyc_q[15] - pop_cyc_q[0]), 32'd15);
    end

    // Backpressure, then simultaneous pop/issue from a full FIFO
    fill_six();
    chk("bp_in_count", 32'(bus.in_count), 32'd4);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_res_valid", 32'(bus.res_valid), 32'd1);
    repeat (3) sync();
    chk("bp_in_count_hold", 32'(bus.in_count), 32'd4);
    chk("bp_queued", 32'(exp_q.size()), 32'd6);
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("sim_in_ready_c0", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("sim_in_ready_c1", 32'(bus.in_ready), 32'd1);
    chk("sim_in_count_c1", 32'(bus.in_count), 32'd3);
    wait_drain();

    // Reset with 3 pairs buffered and 1 in flight
    fill_six();
    bus.res_ready = 1'b1;
    sync();
    chk("rr_in_count", 32'(bus.in_count), 32'd3);
    bus.res_ready = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("rr_in_count_rst", 32'(bus.in_count), 32'd0);
    chk("rr_res_valid_rst", 32'(bus.res_valid), 32'd0);
    chk("rr_res_data_rst", 32'(bus.res_data), 32'd0);
    chk("rr_add_first_rst", 32'(bus.add_first), 32'd0);
    sync();
    rst = 1'b1;
    #1;
    chk("rr_in_ready_rel", 32'(bus.in_ready), 32'd1);
    bus.res_ready = 1'b1;
    pc = pop_cnt;
    repeat (10) sync();
    chk("rr_no_results", 32'(pop_cnt - pc), 32'd0);
    chk("rr_res_valid_rel", 32'(bus.res_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
